// File: rtl/led_phase_scheduler_if.sv
// ADC sample bus and per-channel result bus of the LED phase scheduler.
// The scheduler connects through the slave modport; the sample source and
// result consumer connect through the master modport.
interface led_phase_scheduler_if;
  logic [7:0] ADC;
  logic       adc_strobe;
  logic [7:0] RED_ADC_Value;
  logic [7:0] IR_ADC_Value;
  logic       sample_valid;
  logic       sample_ch;

  modport master (
    output ADC, adc_strobe,
    input  RED_ADC_Value, IR_ADC_Value, sample_valid, sample_ch
  );

  modport slave (
    input  ADC, adc_strobe,
    output RED_ADC_Value, IR_ADC_Value, sample_valid, sample_ch
  );
endinterface

// File: rtl/led_phase_scheduler.sv
// LED phase scheduler: alternates RED and IR illumination phases, each made of
// a settle window followed by an acquisition that averages SAMPLE_CNT strobed
// ADC samples into a per-channel result register.
// Optional macro AMBIENT_PHASE_EN adds a dark (both LEDs off) phase ahead of
// each RED/IR pair; its average is subtracted, clamped at 0, from both results.
//
// state       | meaning
// ------------+------------------------------------------------------------
// IDLE        | LEDs off, front-end settings 0, waiting for enable
// DARK_SETTLE | (AMBIENT_PHASE_EN) LEDs off, front end settling
// DARK_ACQ    | (AMBIENT_PHASE_EN) averaging ambient samples
// RED_SETTLE  | RED LED on, front end settling, strobes ignored
// RED_ACQ     | RED LED on, averaging samples
// IR_SETTLE   | IR LED on, front end settling, strobes ignored
// IR_ACQ      | IR LED on, averaging samples; decides repeat or IDLE
module led_phase_scheduler #(
  parameter int SETTLE_CYC = 4,
  parameter int SAMPLE_CNT = 8
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       enable,
  input  logic [6:0] RED_DC_Comp,
  input  logic [3:0] RED_PGA,
  input  logic [6:0] IR_DC_Comp,
  input  logic [3:0] IR_PGA,
  output logic       LED_RED,
  output logic       LED_IR,
  output logic [6:0] DC_Comp,
  output logic [3:0] PGA_Gain,
  output logic       busy,
  led_phase_scheduler_if.slave bus
);

  localparam int L  = $clog2(SAMPLE_CNT);
  localparam int SW = 8 + L;
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC - 1);
  localparam logic [6:0] LAST_SMP  = 7'(SAMPLE_CNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RED_SETTLE,
    RED_ACQ,
    IR_SETTLE,
    IR_ACQ
`ifdef AMBIENT_PHASE_EN
    ,
    DARK_SETTLE,
    DARK_ACQ
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [6:0]    scnt_q, scnt_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [6:0]    dc_q, dc_d;
  logic [3:0]    pga_q, pga_d;
  logic [7:0]    red_q, red_d;
  logic [7:0]    ir_q, ir_d;
  logic          valid_q, valid_d;
  logic          ch_q, ch_d;
`ifdef AMBIENT_PHASE_EN
  logic [7:0]    dark_q, dark_d;
`endif

  logic [SW-1:0] sum_nx;
  logic [7:0]    avg;
  logic [7:0]    adj;
  logic          acq_done;
  logic          in_settle;
  logic          in_acq;
  state_t        first_state;
  logic [6:0]    first_dc;
  logic [3:0]    first_pga;

  // Next-state, phase settings, accumulation and result update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    scnt_d    = scnt_q;
    sum_d     = sum_q;
    dc_d      = dc_q;
    pga_d     = pga_q;
    red_d     = red_q;
    ir_d      = ir_q;
    valid_d   = 1'b0;
    ch_d      = ch_q;
    in_settle = 1'b0;
    in_acq    = 1'b0;
    sum_nx    = sum_q + SW'(bus.ADC);
    avg       = sum_nx[SW-1:L];
    acq_done  = bus.adc_strobe && (scnt_q == LAST_SMP);
`ifdef AMBIENT_PHASE_EN
    dark_d      = dark_q;
    adj         = (avg > dark_q) ? (avg - dark_q) : 8'd0;
    first_state = DARK_SETTLE;
    first_dc    = 7'd0;
    first_pga   = RED_PGA;
`else
    adj         = avg;
    first_state = RED_SETTLE;
    first_dc    = RED_DC_Comp;
    first_pga   = RED_PGA;
`endif

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = first_state;
          dc_d    = first_dc;
          pga_d   = first_pga;
          cnt_d   = SETTLE_LD;
        end
      end
      RED_SETTLE: begin
        in_settle = 1'b1;
        if (cnt_q == 8'd0) state_d = RED_ACQ;
      end
      RED_ACQ: begin
        in_acq = 1'b1;
        if (acq_done) begin
          red_d   = adj;
          valid_d = 1'b1;
          ch_d    = 1'b0;
          state_d = IR_SETTLE;
          dc_d    = IR_DC_Comp;
          pga_d   = IR_PGA;
          cnt_d   = SETTLE_LD;
        end
      end
      IR_SETTLE: begin
        in_settle = 1'b1;
        if (cnt_q == 8'd0) state_d = IR_ACQ;
      end
      IR_ACQ: begin
        in_acq = 1'b1;
        if (acq_done) begin
          ir_d    = adj;
          valid_d = 1'b1;
          ch_d    = 1'b1;
          if (enable) begin
            state_d = first_state;
            dc_d    = first_dc;
            pga_d   = first_pga;
            cnt_d   = SETTLE_LD;
          end else begin
            state_d = IDLE;
            dc_d    = 7'd0;
            pga_d   = 4'd0;
          end
        end
      end
`ifdef AMBIENT_PHASE_EN
      DARK_SETTLE: begin
        in_settle = 1'b1;
        if (cnt_q == 8'd0) state_d = DARK_ACQ;
      end
      DARK_ACQ: begin
        in_acq = 1'b1;
        if (acq_done) begin
          dark_d  = avg;
          state_d = RED_SETTLE;
          dc_d    = RED_DC_Comp;
          pga_d   = RED_PGA;
          cnt_d   = SETTLE_LD;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Settle down-counter expiry clears the accumulator for the coming ACQ.
    if (in_settle) begin
      if (cnt_q == 8'd0) begin
        sum_d  = '0;
        scnt_d = 7'd0;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end

    if (in_acq && bus.adc_strobe) begin
      sum_d  = sum_nx;
      scnt_d = scnt_q + 7'd1;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      scnt_q  <= 7'd0;
      sum_q   <= '0;
      dc_q    <= 7'd0;
      pga_q   <= 4'd0;
      red_q   <= 8'd0;
      ir_q    <= 8'd0;
      valid_q <= 1'b0;
      ch_q    <= 1'b0;
`ifdef AMBIENT_PHASE_EN
      dark_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
      sum_q   <= sum_d;
      dc_q    <= dc_d;
      pga_q   <= pga_d;
      red_q   <= red_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      ch_q    <= ch_d;
`ifdef AMBIENT_PHASE_EN
      dark_q  <= dark_d;
`endif
    end
  end

  assign LED_RED  = (state_q == RED_SETTLE) || (state_q == RED_ACQ);
  assign LED_IR   = (state_q == IR_SETTLE)  || (state_q == IR_ACQ);
  assign DC_Comp  = dc_q;
  assign PGA_Gain = pga_q;
  assign busy     = (state_q != IDLE);

  assign bus.RED_ADC_Value = red_q;
  assign bus.IR_ADC_Value  = ir_q;
  assign bus.sample_valid  = valid_q;
  assign bus.sample_ch     = ch_q;

endmodule

// File: tb/tb_led_phase_scheduler.sv
// Directed bench for led_phase_scheduler (SETTLE_CYC=4, SAMPLE_CNT=8).
module tb_led_phase_scheduler;
  localparam int SETTLE = 4;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [6:0] RED_DC_Comp = 7'h15;
  logic [3:0] RED_PGA = 4'd3;
  logic [6:0] IR_DC_Comp = 7'h2A;
  logic [3:0] IR_PGA = 4'd9;
  logic       LED_RED, LED_IR, busy;
  logic [6:0] DC_Comp;
  logic [3:0] PGA_Gain;

  led_phase_scheduler_if bus ();

  led_phase_scheduler #(.SETTLE_CYC(4), .SAMPLE_CNT(8)) dut (
    .CLK(CLK), .rst(rst), .enable(enable),
    .RED_DC_Comp(RED_DC_Comp), .RED_PGA(RED_PGA),
    .IR_DC_Comp(IR_DC_Comp), .IR_PGA(IR_PGA),
    .LED_RED(LED_RED), .LED_IR(LED_IR),
    .DC_Comp(DC_Comp), .PGA_Gain(PGA_Gain), .busy(busy),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stimulus source state.
  logic [7:0] red_val = 8'd100;
  logic [7:0] ir_val = 8'd200;
  logic [7:0] dark_val = 8'd0;
  bit         alt = 1'b0;
  bit         spam = 1'b0;
  bit         alt_bit = 1'b0;
  int         red_age = 0;
  int         ir_age = 0;
  int         ir_acq_str = 0;
  bit         prev_r = 1'b0;
  bit         prev_i = 1'b0;
  int         tick = 0;

  // ADC source: strobe every 3 cycles, value chosen by the lit LED.
  initial begin
    bit settling;
    bus.ADC = 8'd0;
    bus.adc_strobe = 1'b0;
    forever begin
      @(negedge CLK);
      red_age = (LED_RED && prev_r) ? red_age + 1 : 0;
      ir_age  = (LED_IR && prev_i) ? ir_age + 1 : 0;
      prev_r  = LED_RED;
      prev_i  = LED_IR;
      if (!LED_IR) ir_acq_str = 0;
      tick = (tick == 2) ? 0 : tick + 1;
      settling = (LED_RED && red_age < SETTLE) || (LED_IR && ir_age < SETTLE);
      if (spam && settling) begin
        bus.adc_strobe = 1'b1;
        bus.ADC = 8'd255;
      end else if (tick == 0) begin
        bus.adc_strobe = 1'b1;
        if (LED_RED) begin
          if (alt) begin
            bus.ADC = alt_bit ? 8'd255 : 8'd0;
            alt_bit = ~alt_bit;
          end else bus.ADC = red_val;
        end else if (LED_IR) begin
          bus.ADC = ir_val;
          if (!settling) ir_acq_str++;
        end else bus.ADC = dark_val;
      end else begin
        bus.adc_strobe = 1'b0;
        bus.ADC = 8'hEE;
      end
    end
  end

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    @(negedge CLK);
    while (!bus.sample_valid && n < 400) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_timeout"}, 32'(n >= 400), 0);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_led_red"}, LED_RED, 0);
    chk({tag, "_led_ir"}, LED_IR, 0);
    chk({tag, "_dc"}, DC_Comp, 0);
    chk({tag, "_pga"}, PGA_Gain, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, bus.sample_valid, 0);
    chk({tag, "_ch"}, bus.sample_ch, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge CLK);
    chk_idle_zero("rst");
    chk("rst_red", bus.RED_ADC_Value, 0);
    chk("rst_ir", bus.IR_ADC_Value, 0);

    // Basic pair: RED=100, IR=200
    rst = 1'b0;
    enable = 1'b1;
    @(negedge CLK);
    chk("start_busy", busy, 1);
`ifdef AMBIENT_PHASE_EN
    chk("start_led_red", LED_RED, 0);
    chk("start_dc", DC_Comp, 0);
`else
    chk("start_led_red", LED_RED, 1);
    chk("start_dc", DC_Comp, 7'h15);
`endif
    chk("start_pga", PGA_Gain, 3);
    n = 0;
    while (!LED_RED && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("red_phase_dc", DC_Comp, 7'h15);
    RED_DC_Comp = 7'h7F;
    RED_PGA = 4'd12;
    repeat (3) @(negedge CLK);
    chk("red_hold_dc", DC_Comp, 7'h15);
    chk("red_hold_pga", PGA_Gain, 3);
    chk("red_hold_leds", {LED_RED, LED_IR}, 2'b10);

    wait_valid("red1");
    chk("red1_ch", bus.sample_ch, 0);
    chk("red1_val", bus.RED_ADC_Value, 100);
    chk("ir_phase_leds", {LED_RED, LED_IR}, 2'b01);
    chk("ir_phase_dc", DC_Comp, 7'h2A);
    chk("ir_phase_pga", PGA_Gain, 9);
    @(negedge CLK);
    chk("valid_pulse_width", bus.sample_valid, 0);
    wait_valid("ir1");
    chk("ir1_ch", bus.sample_ch, 1);
    chk("ir1_val", bus.IR_ADC_Value, 200);
    chk("ir1_red_held", bus.RED_ADC_Value, 100);
    chk("repeat_busy", busy, 1);
`ifdef AMBIENT_PHASE_EN
    chk("repeat_leds", {LED_RED, LED_IR}, 2'b00);
`else
    chk("repeat_leds", {LED_RED, LED_IR}, 2'b10);
    chk("repeat_dc_new", DC_Comp, 7'h7F);
`endif

    // Truncation: alternating 0/255 -> 127
    alt = 1'b1;
    wait_valid("alt");
    chk("alt_ch", bus.sample_ch, 0);
    chk("alt_val", bus.RED_ADC_Value, 127);
    alt = 1'b0;
    wait_valid("alt_ir");
    chk("alt_ir_val", bus.IR_ADC_Value, 200);

    // Strobes during settle ignored: 255 in settle, 10/90 in ACQ
    spam = 1'b1;
    red_val = 8'd10;
    ir_val = 8'd90;
    wait_valid("spam_red");
    chk("spam_red_val", bus.RED_ADC_Value, 10);
    wait_valid("spam_ir");
    chk("spam_ir_val", bus.IR_ADC_Value, 90);
    spam = 1'b0;

    // enable dropped during RED_ACQ: pair completes, then IDLE
    red_val = 8'd77;
    ir_val = 8'd55;
    n = 0;
    while (!(LED_RED && red_age >= SETTLE + 2) && n < 400) begin
      @(negedge CLK);
      n++;
    end
    chk("drop_reach_acq_timeout", 32'(n >= 400), 0);
    enable = 1'b0;
    wait_valid("drop_red");
    chk("drop_red_val", bus.RED_ADC_Value, 77);
    wait_valid("drop_ir");
    chk("drop_ir_val", bus.IR_ADC_Value, 55);
    chk("drop_ir_ch", bus.sample_ch, 1);
    @(negedge CLK);
    chk("drop_busy", busy, 0);
    chk("drop_leds", {LED_RED, LED_IR}, 2'b00);
    chk("drop_dc", DC_Comp, 0);
    chk("drop_pga", PGA_Gain, 0);
    repeat (10) @(negedge CLK);
    chk("idle_busy", busy, 0);
    chk("idle_red_held", bus.RED_ADC_Value, 77);
    chk("idle_ir_held", bus.IR_ADC_Value, 55);

    // Reset mid IR_ACQ after 5 strobes
    red_val = 8'd100;
    ir_val = 8'd200;
    enable = 1'b1;
    n = 0;
    while (ir_acq_str < 5 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    chk("mid_ir_timeout", 32'(n >= 400), 0);
    @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK);
    chk_idle_zero("midrst");
    chk("midrst_red", bus.RED_ADC_Value, 0);
    chk("midrst_ir", bus.IR_ADC_Value, 0);
    enable = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge CLK);
    chk("post_rst_wait_busy", busy, 0);
    enable = 1'b1;
    @(negedge CLK);
    chk("restart_busy", busy, 1);
    wait_valid("restart_red");
    chk("restart_red_val", bus.RED_ADC_Value, 100);
    chk("restart_red_ch", bus.sample_ch, 0);
    wait_valid("restart_ir");
    chk("restart_ir_val", bus.IR_ADC_Value, 200);
    chk("restart_ir_ch", bus.sample_ch, 1);

`ifdef AMBIENT_PHASE_EN
    // Ambient subtraction: dark 30, RED 100 -> 70, IR 20 -> 0
    @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK);
    rst = 1'b0;
    dark_val = 8'd30;
    red_val = 8'd100;
    ir_val = 8'd20;
    wait_valid("amb_red");
    chk("amb_red_ch", bus.sample_ch, 0);
    chk("amb_red_val", bus.RED_ADC_Value, 70);
    wait_valid("amb_ir");
    chk("amb_ir_val", bus.IR_ADC_Value, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/led_phase_scheduler.md
LED_PHASE_SCHEDULER -- requirements
Module: led_phase_scheduler

Interface
REQ-001 Parameter: SETTLE_CYC, default 4, CLK cycles of LED/analog settling per phase (legal range 1..255).
REQ-002 Parameter: SAMPLE_CNT, default 8, ADC samples averaged per phase (power of 2, 1..64).
REQ-003 Port: CLK  in  1  single system clock; all logic on posedge CLK.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: enable  in  1  run request; level-sensitive.
REQ-006 Port: RED_DC_Comp  in  7  DC compensation for the RED phase.
REQ-007 Port: RED_PGA  in  4  PGA gain for the RED phase.
REQ-008 Port: IR_DC_Comp  in  7  DC compensation for the IR phase.
REQ-009 Port: IR_PGA  in  4  PGA gain for the IR phase.
REQ-010 Port: ADC  in  8  converter sample.
REQ-011 Port: adc_strobe  in  1  one-cycle pulse; ADC is valid in this cycle.
REQ-012 Port: LED_RED, LED_IR  out  1 each  LED enables.
REQ-013 Port: DC_Comp  out  7, PGA_Gain  out  4  applied front-end settings.
REQ-014 Port: RED_ADC_Value, IR_ADC_Value  out  8 each  latest per-channel averages.
REQ-015 Port: sample_valid  out  1  one-cycle pulse when a channel value updates; sample_ch  out  1  channel of that update (0 RED, 1 IR).
REQ-016 Port: busy  out  1  high in every state except IDLE.

Function
REQ-017 States: IDLE, RED_SETTLE, RED_ACQ, IR_SETTLE, IR_ACQ (plus DARK_SETTLE, DARK_ACQ per REQ-031).
REQ-018 IDLE: LEDs off, DC_Comp=0, PGA_Gain=0; enable=1 -> RED_SETTLE next cycle.
REQ-019 On each SETTLE entry, the phase's DC_Comp/PGA_Gain are sampled from inputs and held constant for the whole SETTLE+ACQ phase; input changes mid-phase are ignored.
REQ-020 RED phases: LED_RED=1, LED_IR=0; IR phases: LED_RED=0, LED_IR=1; the two LEDs are never high together.
REQ-021 SETTLE lasts exactly SETTLE_CYC cycles, then -> matching ACQ; adc_strobe during SETTLE is ignored.
REQ-022 ACQ accumulates ADC on each adc_strobe into an (8+log2 SAMPLE_CNT)-bit sum cleared at ACQ entry; no overflow possible.
REQ-023 On the SAMPLE_CNT-th strobe: the cycle after, the channel value = sum >> log2(SAMPLE_CNT) (truncating) is registered, sample_valid pulses 1 cycle, sample_ch set; FSM leaves ACQ that same cycle.
REQ-024 RED_ACQ -> IR_SETTLE; IR_ACQ -> RED_SETTLE (or first phase per REQ-031) if enable=1, else IDLE.
REQ-025 enable deassertion mid-sequence completes the current RED/IR pair before IDLE; values are never partially updated.
REQ-026 No ACQ timeout: with no strobes the FSM waits indefinitely.
REQ-027 Channel values hold until overwritten; unaffected by IDLE.

Reset
REQ-028 rst=1 at any cycle (including mid-ACQ) forces IDLE on the next edge: LEDs 0, DC_Comp 0, PGA_Gain 0, RED/IR_ADC_Value 0, sample_valid 0, sample_ch 0, busy 0, counters and sum 0.
REQ-029 rst has priority over enable and adc_strobe.
REQ-030 After rst release, RED_SETTLE is entered no earlier than the cycle after enable is sampled high.

Configuration
REQ-031 Macro AMBIENT_PHASE_EN defined: sequence is DARK_SETTLE -> DARK_ACQ -> RED... per pair; DARK uses both LEDs off, DC_Comp=0, PGA_Gain=RED_PGA; dark average stored (reset 0, no sample_valid); RED/IR values = saturating (average - dark), clamped at 0.
REQ-032 AMBIENT_PHASE_EN undefined: no DARK states or dark register; values are raw averages.

Verification
REQ-033 Reset then enable=1, SETTLE_CYC=4, SAMPLE_CNT=8, strobe every 3 cycles, ADC=100 in RED, 200 in IR -> RED_ADC_Value=100 (sample_ch=0), then IR_ADC_Value=200 (sample_ch=1), one sample_valid each.
REQ-034 ADC alternating 0/255 in RED -> RED_ADC_Value=127 (truncation).
REQ-035 Strobes in SETTLE cycles with ADC=255, ACQ ADC=10 -> value=10.
REQ-036 enable dropped during RED_ACQ -> IR phase still completes, then IDLE, busy=0, LEDs off.
REQ-037 rst pulsed mid-IR_ACQ after 5 strobes -> all outputs per REQ-028 next cycle; restart yields clean averages.
REQ-038 With AMBIENT_PHASE_EN: dark ADC=30, RED ADC=100, IR ADC=20 -> RED_ADC_Value=70, IR_ADC_Value=0.
